// File: rtl/opc5ls_bus_pkg.sv
// Shared types and bus widths for the OPC5LS CPU-to-SRAM bridge.
package opc5ls_bus_pkg;

    localparam int CPU_AW = 16;
    localparam int CPU_DW = 16;
    localparam int RAM_AW = 17;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/opc5ls_sram_phase.sv
// Byte-phase sequencer: times one N-cycle SRAM byte access and drives its strobes.
// start is held high for the whole phase; back-to-back phases just keep it high.
module opc5ls_sram_phase #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_b,
    input  logic start,
    input  logic rnw,
    output logic ce_b,
    output logic oe_b,
    output logic we_b,
    output logic sample,
    output logic done
);

    localparam int CW = 4;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(WAIT_CYCLES));

    // Wrapping at the last cycle lets the next phase start at 0 without a gap.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            cnt <= '0;
        else if (!start || last)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign ce_b   = !start;
    assign oe_b   = !(start && rnw);
    // The final cycle of a write phase holds data with WE released.
    assign we_b   = !(start && !rnw && !last);
    assign sample = start && rnw && last;
    assign done   = start && last;

endmodule

// File: rtl/opc5ls_sram_bridge.sv
// OPC5LS bus responder: splits each 16-bit CPU access into two 8-bit SRAM accesses.
// Optional write protection above PROT_BASE is enabled by OPC5LS_BRIDGE_WPROT_EN.
module opc5ls_sram_bridge
    import opc5ls_bus_pkg::*;
#(
    parameter int                WAIT_CYCLES = 1,
    parameter logic [CPU_AW-1:0] PROT_BASE   = 16'hF000
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              cpu_vpa,
    input  logic              cpu_vda,
    input  logic              cpu_rnw,
    input  logic [CPU_AW-1:0] cpu_address,
    input  logic [CPU_DW-1:0] cpu_dout,
    output logic [CPU_DW-1:0] cpu_din,
    output logic              cpu_clken,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_dq_out,
    input  logic [RAM_DW-1:0] ram_dq_in,
    output logic              ram_dq_oe,
    output logic              ram_ce_b,
    output logic              ram_oe_b,
    output logic              ram_we_b
);

`ifdef OPC5LS_BRIDGE_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    bridge_state_e     state;
    logic [CPU_AW-1:0] addr_q;
    logic [CPU_DW-1:0] dout_q;
    logic              rnw_q;
    logic [RAM_DW-1:0] lo_q;

    logic req, drop, take, in_phase, byte_sel;
    logic ph_sample, ph_done;

    assign req      = cpu_vpa || cpu_vda;
    assign drop     = WPROT && !cpu_rnw && (cpu_address >= PROT_BASE);
    assign take     = (state == ST_IDLE) && req && !drop;
    assign in_phase = (state == ST_LO) || (state == ST_HI);
    assign byte_sel = (state == ST_HI);

    opc5ls_sram_phase #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_phase (
        .clk    (clk),
        .reset_b(reset_b),
        .start  (in_phase),
        .rnw    (rnw_q),
        .ce_b   (ram_ce_b),
        .oe_b   (ram_oe_b),
        .we_b   (ram_we_b),
        .sample (ph_sample),
        .done   (ph_done)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            dout_q  <= '0;
            rnw_q   <= 1'b1;
            lo_q    <= '0;
            cpu_din <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (take) begin
                    addr_q <= cpu_address;
                    dout_q <= cpu_dout;
                    rnw_q  <= cpu_rnw;
                    state  <= ST_LO;
                end
                ST_LO: begin
                    if (ph_sample) lo_q <= ram_dq_in;
                    if (ph_done)   state <= ST_HI;
                end
                ST_HI: begin
                    if (ph_sample) cpu_din <= {ram_dq_in, lo_q};
                    if (ph_done)   state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only IDLE looks at the live request; vpa/vda come from CPU registers, so no loop.
    assign cpu_clken  = !reset_b || (state == ST_DONE) || ((state == ST_IDLE) && !take);
    assign ram_addr   = {addr_q, byte_sel};
    assign ram_dq_oe  = in_phase && !rnw_q;
    assign ram_dq_out = byte_sel ? dout_q[15:8] : dout_q[7:0];

endmodule

// File: tb/tb_opc5ls_sram_bridge.sv
// Directed bench for opc5ls_sram_bridge: WAIT_CYCLES=1 instance with SRAM model, WAIT_CYCLES=3 for back-to-back.
module tb_opc5ls_sram_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_b;
    logic        vpa, vda, rnw;
    logic [15:0] address, dout, din;
    logic        clken;
    logic [16:0] ram_addr;
    logic [7:0]  dq_out, dq_in;
    logic        dq_oe, ce_b, oe_b, we_b;

    logic        vpa_b;
    logic [15:0] address_b, din_b;
    logic        clken_b;
    logic [16:0] ram_addr_b;
    logic [7:0]  dq_out_b, dq_in_b;
    logic        dq_oe_b, ce_b_b, oe_b_b, we_b_b;

    opc5ls_sram_bridge #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset_b(reset_b), .cpu_vpa(vpa), .cpu_vda(vda), .cpu_rnw(rnw),
        .cpu_address(address), .cpu_dout(dout), .cpu_din(din), .cpu_clken(clken),
        .ram_addr(ram_addr), .ram_dq_out(dq_out), .ram_dq_in(dq_in), .ram_dq_oe(dq_oe),
        .ram_ce_b(ce_b), .ram_oe_b(oe_b), .ram_we_b(we_b)
    );

    opc5ls_sram_bridge #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset_b(reset_b), .cpu_vpa(vpa_b), .cpu_vda(1'b0), .cpu_rnw(1'b1),
        .cpu_address(address_b), .cpu_dout(16'h0000), .cpu_din(din_b), .cpu_clken(clken_b),
        .ram_addr(ram_addr_b), .ram_dq_out(dq_out_b), .ram_dq_in(dq_in_b), .ram_dq_oe(dq_oe_b),
        .ram_ce_b(ce_b_b), .ram_oe_b(oe_b_b), .ram_we_b(we_b_b)
    );

    // SRAM model: contents reload while reset is held, writes land on the clock with WE low.
    logic [7:0] mem [0:255];
    assign dq_in   = mem[ram_addr[7:0]];
    assign dq_in_b = ram_addr_b[7:0] ^ 8'h5A;

    always @(posedge clk) begin
        if (!reset_b) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h08] <= 8'h34;
            mem[8'h09] <= 8'h12;
            mem[8'h00] <= 8'h77;
            mem[8'h01] <= 8'h66;
        end else if (!we_b && !ce_b) begin
            mem[ram_addr[7:0]] <= dq_out;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU access; inputs are scrambled after the request cycle to prove they are latched.
    task automatic access(input logic pa, input logic da, input logic wr_n,
                          input logic [15:0] a, input logic [15:0] d,
                          output logic req_ck, output int low, output int oel,
                          output int wel, output int dqoe,
                          output logic [16:0] a_first, output logic [16:0] a_last);
        low = 0; oel = 0; wel = 0; dqoe = 0; a_first = '0; a_last = '0;
        @(posedge clk); #1;
        vpa = pa; vda = da; rnw = wr_n; address = a; dout = d;
        @(negedge clk);
        req_ck = clken;
        @(posedge clk); #1;
        vpa = 1'b0; vda = 1'b0; rnw = ~wr_n; address = 16'hFFFF; dout = 16'h5555;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clken) break;
            if (low == 0) a_first = ram_addr;
            a_last = ram_addr;
            low++;
            if (!oe_b)  oel++;
            if (!we_b)  wel++;
            if (dq_oe)  dqoe++;
        end
        if (!clken) chk("access_timeout", 32'd1, 32'd0);
    endtask

    logic        rq;
    int          low, oel, wel, dqoe;
    logic [16:0] af, al;
    logic        bad;
    logic [19:0] pat;
    logic [15:0] d1, d2;

    initial begin
        reset_b = 1'b0;
        vpa = 1'b0; vda = 1'b0; rnw = 1'b1; address = '0; dout = '0;
        vpa_b = 1'b0; address_b = '0;

        @(negedge clk);
        chk("rst_clken", clken, 1);
        chk("rst_strobes", {ce_b, oe_b, we_b, dq_oe}, 4'b1110);
        chk("rst_bus", {ram_addr, dq_out, din}, 41'd0);
        @(posedge clk); #1 reset_b = 1'b1;

        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (clken !== 1'b1 || ce_b !== 1'b1) bad = 1'b1;
        end
        chk("idle_bus", bad, 0);

        access(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("rd_req_clken", rq, 0);
        chk("rd_stall_cycles", low, 4);
        chk("rd_oe_cycles", oel, 4);
        chk("rd_no_we", {wel, dqoe}, 0);
        chk("rd_addr_lo", af, 17'h00008);
        chk("rd_addr_hi", al, 17'h00009);
        chk("rd_din", din, 16'h1234);
        @(negedge clk);
        chk("rd_back_idle", {clken, ce_b}, 2'b11);

        access(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, rq, low, oel, wel, dqoe, af, al);
        chk("wr_stall_cycles", low, 4);
        chk("wr_we_cycles", wel, 2);
        chk("wr_dq_oe_cycles", dqoe, 4);
        chk("wr_no_oe", oel, 0);
        chk("wr_mem_lo", mem[8'h20], 8'hEF);
        chk("wr_mem_hi", mem[8'h21], 8'hBE);
        chk("wr_din_kept", din, 16'h1234);

        access(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("rd_back_beef", din, 16'hBEEF);

        access(1'b0, 1'b1, 1'b1, 16'hF100, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("prot_rd_cycles", low, 4);
        chk("prot_rd_din", din, 16'h6677);

        access(1'b0, 1'b1, 1'b0, 16'hF100, 16'hA5C3, rq, low, oel, wel, dqoe, af, al);
`ifdef OPC5LS_BRIDGE_WPROT_EN
        chk("prot_wr_clken", rq, 1);
        chk("prot_wr_stall", low, 0);
        access(1'b0, 1'b1, 1'b1, 16'hF100, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("prot_rd_after", din, 16'h6677);
`else
        chk("wr_f100_we", wel, 2);
        access(1'b0, 1'b1, 1'b1, 16'hF100, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("wr_f100_back", din, 16'hA5C3);
`endif

        // Abort a write during its high byte.
        @(posedge clk); #1;
        vda = 1'b1; rnw = 1'b0; address = 16'h0030; dout = 16'h1111;
        @(posedge clk); #1 vda = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_addr[0]) break;
        end
        chk("hi_we_active", {ram_addr, we_b}, {17'h00061, 1'b0});
        reset_b = 1'b0;
        #1;
        chk("rst_abort_strobes", {we_b, ce_b, clken}, 3'b111);
        @(posedge clk); #1 reset_b = 1'b1;
        @(negedge clk);
        chk("rst_abort_idle", {clken, ce_b, din}, {2'b11, 16'h0000});
        access(1'b0, 1'b1, 1'b1, 16'h0004, 16'h0000, rq, low, oel, wel, dqoe, af, al);
        chk("post_rst_rd", {low[7:0], din}, {8'd4, 16'h1234});

        // Back-to-back fetches on the WAIT_CYCLES=3 instance.
        pat = '0; bad = 1'b0; d1 = '0; d2 = '0;
        @(posedge clk); #1 vpa_b = 1'b1; address_b = 16'h0002;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            pat[c] = clken_b;
            if (c == 9)  d1 = din_b;
            if (c == 19) d2 = din_b;
            if (we_b_b !== 1'b1 || dq_oe_b !== 1'b0 || dq_out_b !== 8'h00 || oe_b_b !== ce_b_b) bad = 1'b1;
            if (c == 0) begin
                @(posedge clk); #1 address_b = 16'h0003;
            end
        end
        vpa_b = 1'b0;
        chk("b2b_clken_pattern", pat, 20'h80200);
        chk("b2b_din_first", d1, 16'h5F5E);
        chk("b2b_din_second", d2, 16'h5D5C);
        chk("b2b_strobes", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
